// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin arbiter between icache refills and dcache refills/writebacks onto one DRAM port
module riscv_mem_arbiter #(
    parameter int AWIDTH  = 23,
    parameter int DWIDTH  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              i_riscv_memarb_clk,
    input  logic              i_riscv_memarb_rst,
    input  logic              i_riscv_memarb_ic_req,
    input  logic [AWIDTH-1:0] i_riscv_memarb_ic_addr,
    output logic              o_riscv_memarb_ic_ack,
    output logic [DWIDTH-1:0] o_riscv_memarb_ic_data,
    input  logic              i_riscv_memarb_dc_rden,
    input  logic              i_riscv_memarb_dc_wren,
    input  logic [AWIDTH-1:0] i_riscv_memarb_dc_addr,
    input  logic [DWIDTH-1:0] i_riscv_memarb_dc_wdata,
    output logic              o_riscv_memarb_dc_ack,
    output logic [DWIDTH-1:0] o_riscv_memarb_dc_data,
    output logic              o_riscv_memarb_mem_rden,
    output logic              o_riscv_memarb_mem_wren,
    output logic [AWIDTH-1:0] o_riscv_memarb_mem_addr,
    output logic [DWIDTH-1:0] o_riscv_memarb_mem_wdata,
    input  logic [DWIDTH-1:0] i_riscv_memarb_mem_rdata,
    input  logic              i_riscv_memarb_mem_ready,
    output logic              o_riscv_memarb_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SERVE_IC, SERVE_DC} state_t;

    state_t            state_q;
    logic              last_dc_q;
    logic [CW-1:0]     wait_q;
    logic              mem_rden_q;
    logic              mem_wren_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_wdata_q;
    logic              timeout_q;
    logic              ic_pend;
    logic              dc_pend;
    logic              grant_ic;
    logic              grant_dc;

    // Round-robin pick: dcache wins unless both pend and dcache had the last grant
    always_comb begin
        ic_pend  = i_riscv_memarb_ic_req;
        dc_pend  = i_riscv_memarb_dc_rden | i_riscv_memarb_dc_wren;
        grant_dc = dc_pend && (!ic_pend || !last_dc_q);
        grant_ic = ic_pend && !grant_dc;
    end

    // Arbitration FSM: capture request on grant, hold mem strobes until ready or timeout
    always_ff @(posedge i_riscv_memarb_clk) begin
        if (!i_riscv_memarb_rst) begin
            state_q     <= IDLE;
            last_dc_q   <= 1'b1;
            wait_q      <= '0;
            mem_rden_q  <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_ic || grant_dc) begin
                        state_q    <= grant_dc ? SERVE_DC : SERVE_IC;
                        last_dc_q  <= grant_dc;
                        wait_q     <= '0;
                        mem_addr_q <= grant_dc ? i_riscv_memarb_dc_addr : i_riscv_memarb_ic_addr;
                        mem_wren_q <= grant_dc && i_riscv_memarb_dc_wren;
                        mem_rden_q <= grant_ic || !i_riscv_memarb_dc_wren;
                        if (grant_dc)
                            mem_wdata_q <= i_riscv_memarb_dc_wdata;
                    end
                end
                default: begin
                    if (i_riscv_memarb_mem_ready) begin
                        state_q    <= IDLE;
                        mem_rden_q <= 1'b0;
                        mem_wren_q <= 1'b0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                        if (wait_q == TMAX) begin
                            state_q    <= IDLE;
                            mem_rden_q <= 1'b0;
                            mem_wren_q <= 1'b0;
                            timeout_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_riscv_memarb_ic_ack    = i_riscv_memarb_rst && state_q == SERVE_IC && i_riscv_memarb_mem_ready;
    assign o_riscv_memarb_dc_ack    = i_riscv_memarb_rst && state_q == SERVE_DC && i_riscv_memarb_mem_ready;
    assign o_riscv_memarb_ic_data   = i_riscv_memarb_mem_rdata;
    assign o_riscv_memarb_dc_data   = i_riscv_memarb_mem_rdata;
    assign o_riscv_memarb_mem_rden  = mem_rden_q;
    assign o_riscv_memarb_mem_wren  = mem_wren_q;
    assign o_riscv_memarb_mem_addr  = mem_addr_q;
    assign o_riscv_memarb_mem_wdata = mem_wdata_q;
    assign o_riscv_memarb_timeout   = timeout_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed table, corner sequences and randomized model check of the memory arbiter
module tb_riscv_mem_arbiter;
    localparam int AW = 23;
    localparam int DW = 128;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_ack;
    logic [DW-1:0] ic_data;
    logic          dc_rden = 1'b0;
    logic          dc_wren = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [DW-1:0] dc_wdata = '0;
    logic          dc_ack;
    logic [DW-1:0] dc_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          tmo;

    int n_chk = 0;
    int n_fail = 0;

    riscv_mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
        .i_riscv_memarb_clk       (clk),
        .i_riscv_memarb_rst       (rst_n),
        .i_riscv_memarb_ic_req    (ic_req),
        .i_riscv_memarb_ic_addr   (ic_addr),
        .o_riscv_memarb_ic_ack    (ic_ack),
        .o_riscv_memarb_ic_data   (ic_data),
        .i_riscv_memarb_dc_rden   (dc_rden),
        .i_riscv_memarb_dc_wren   (dc_wren),
        .i_riscv_memarb_dc_addr   (dc_addr),
        .i_riscv_memarb_dc_wdata  (dc_wdata),
        .o_riscv_memarb_dc_ack    (dc_ack),
        .o_riscv_memarb_dc_data   (dc_data),
        .o_riscv_memarb_mem_rden  (mem_rden),
        .o_riscv_memarb_mem_wren  (mem_wren),
        .o_riscv_memarb_mem_addr  (mem_addr),
        .o_riscv_memarb_mem_wdata (mem_wdata),
        .i_riscv_memarb_mem_rdata (mem_rdata),
        .i_riscv_memarb_mem_ready (mem_ready),
        .o_riscv_memarb_timeout   (tmo)
    );

    always #5 clk = ~clk;

    // rst ic dcr dcw rdy | exp rden wren ic_ack dc_ack timeout | addr select (1 = dcache)
    typedef struct packed {
        logic rst, ic, dcr, dcw, rdy, er, ew, eia, eda, eto, esel;
    } vec_t;

    typedef struct {
        bit            active;
        bit            is_dc;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waited;
    } txn_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string t, input logic er, input logic ew, input logic eia, input logic eda, input logic eto);
        chk({t, " rden"}, DW'(mem_rden), DW'(er));
        chk({t, " wren"}, DW'(mem_wren), DW'(ew));
        chk({t, " ic_ack"}, DW'(ic_ack), DW'(eia));
        chk({t, " dc_ack"}, DW'(dc_ack), DW'(eda));
        chk({t, " timeout"}, DW'(tmo), DW'(eto));
    endtask

    task automatic drive(input logic r, input logic ic, input logic dr, input logic dw, input logic rd);
        rst_n = r;
        ic_req = ic;
        dc_rden = dr;
        dc_wren = dw;
        mem_ready = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        txn_t cur;
        bit   last_dc;
        bit   m_to;
        tbl[0]  = 11'b11000_00000_0;
        tbl[1]  = 11'b10000_10000_0;
        tbl[2]  = 11'b10000_10000_0;
        tbl[3]  = 11'b10001_10100_0;
        tbl[4]  = 11'b10000_00000_0;
        tbl[5]  = 11'b00000_00000_0;
        tbl[6]  = 11'b11100_00000_0;
        tbl[7]  = 11'b11101_10100_0;
        tbl[8]  = 11'b11100_00000_0;
        tbl[9]  = 11'b10001_10010_1;
        tbl[10] = 11'b11100_00000_0;
        tbl[11] = 11'b10000_10000_0;
        tbl[12] = 11'b10001_10100_0;
        tbl[13] = 11'b10000_00000_0;

        drive(0, 0, 0, 0, 0);
        repeat (2) tick();
        @(negedge clk);
        expect_out("reset", 0, 0, 0, 0, 0);
        chk("reset addr", DW'(mem_addr), '0);
        chk("reset wdata", mem_wdata, '0);
        tick();

        ic_addr = 23'h00010;
        dc_addr = 23'h00020;
        mem_rdata = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].ic, tbl[i].dcr, tbl[i].dcw, tbl[i].rdy);
            @(negedge clk);
            expect_out($sformatf("vec%0d", i), tbl[i].er, tbl[i].ew, tbl[i].eia, tbl[i].eda, tbl[i].eto);
            if (tbl[i].er || tbl[i].ew)
                chk($sformatf("vec%0d addr", i), DW'(mem_addr), DW'(tbl[i].esel ? dc_addr : ic_addr));
            if (tbl[i].eia)
                chk($sformatf("vec%0d ic_data", i), ic_data, mem_rdata);
            if (tbl[i].eda)
                chk($sformatf("vec%0d dc_data", i), dc_data, mem_rdata);
            tick();
        end

        // write wins over simultaneous read
        dc_addr = 23'h7FFFFF;
        dc_wdata = '1;
        drive(1, 0, 1, 1, 0);
        @(negedge clk);
        expect_out("wr idle", 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        dc_wdata = '0;
        @(negedge clk);
        expect_out("wr serve", 0, 1, 0, 0, 0);
        chk("wr addr", DW'(mem_addr), DW'(23'h7FFFFF));
        chk("wr wdata", mem_wdata, '1);
        tick();
        drive(1, 0, 0, 0, 1);
        @(negedge clk);
        expect_out("wr done", 0, 1, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        expect_out("wr after", 0, 0, 0, 0, 0);
        tick();

        // timeout after TO wait cycles, then a normal grant
        dc_addr = 23'h00020;
        drive(1, 0, 1, 0, 0);
        @(negedge clk);
        expect_out("to idle", 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        for (int w = 0; w < TO; w++) begin
            @(negedge clk);
            expect_out($sformatf("to wait%0d", w), 1, 0, 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, 0, 1);
        @(negedge clk);
        expect_out("to pulse", 0, 0, 0, 0, 1);
        tick();
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        expect_out("to post", 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1);
        @(negedge clk);
        expect_out("to regrant", 1, 0, 1, 0, 0);
        chk("to regrant addr", DW'(mem_addr), DW'(ic_addr));
        tick();

        // reset during SERVE_DC abandons the transfer
        drive(1, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        expect_out("rst serve", 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        expect_out("rst release", 0, 0, 0, 0, 0);
        chk("rst addr", DW'(mem_addr), '0);
        chk("rst wdata", mem_wdata, '0);
        tick();
        drive(1, 0, 0, 0, 1);
        @(negedge clk);
        expect_out("rst late ready", 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        expect_out("idle ready after", 0, 0, 0, 0, 0);
        tick();

        // randomized run against a transaction-level model
        cur = '{default: 0};
        last_dc = 1;
        m_to = 0;
        for (int i = 0; i < 3000; i++) begin
            drive(i == 0 ? 1'b0 : ($urandom_range(0, 63) != 0), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            ic_addr = AW'($urandom);
            dc_addr = AW'($urandom);
            dc_wdata = {$urandom, $urandom, $urandom, $urandom};
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (i > 0) begin
                logic eia, eda;
                eia = rst_n && cur.active && !cur.is_dc && mem_ready;
                eda = rst_n && cur.active && cur.is_dc && mem_ready;
                expect_out("rand", cur.active && !cur.wr, cur.active && cur.wr, eia, eda, m_to);
                if (cur.active)
                    chk("rand addr", DW'(mem_addr), DW'(cur.addr));
                if (cur.active && cur.wr)
                    chk("rand wdata", mem_wdata, cur.wdata);
                if (eia)
                    chk("rand ic_data", ic_data, mem_rdata);
                if (eda)
                    chk("rand dc_data", dc_data, mem_rdata);
            end
            if (!rst_n) begin
                cur.active = 0;
                last_dc = 1;
                m_to = 0;
            end else begin
                m_to = 0;
                if (cur.active) begin
                    if (mem_ready)
                        cur.active = 0;
                    else begin
                        cur.waited++;
                        if (cur.waited == TO) begin
                            cur.active = 0;
                            m_to = 1;
                        end
                    end
                end else if (ic_req || dc_rden || dc_wren) begin
                    cur.is_dc = (dc_rden || dc_wren) && !(ic_req && last_dc);
                    cur.active = 1;
                    cur.waited = 0;
                    cur.wr = cur.is_dc && dc_wren;
                    cur.addr = cur.is_dc ? dc_addr : ic_addr;
                    cur.wdata = dc_wdata;
                    last_dc = cur.is_dc;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
